// File: rtl/quad_demux_router.sv
// quad_demux_router: registered 1-to-2 demux with per-channel valid/ready output registers and accept counters
module quad_demux_router #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic             E,
  output logic [WIDTH-1:0] A,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [WIDTH-1:0] B,
  output logic             B_valid,
  input  logic             B_ready,
  output logic [CNT_W-1:0] cnt_A,
  output logic [CNT_W-1:0] cnt_B
);
  logic ld_a, ld_b;
  assign in_ready = E & (S ? (~B_valid | B_ready) : (~A_valid | A_ready));
  assign ld_a = in_valid & in_ready & ~S;
  assign ld_b = in_valid & in_ready & S;
  always_ff @(posedge clk) begin
    if (rst) begin
      A       <= '0;
      B       <= '0;
      A_valid <= 1'b0;
      B_valid <= 1'b0;
      cnt_A   <= '0;
      cnt_B   <= '0;
    end else begin
      // a load on the same edge as a delivery keeps the channel full
      A_valid <= ld_a | (A_valid & ~A_ready);
      B_valid <= ld_b | (B_valid & ~B_ready);
      if (ld_a) begin
        A     <= in;
        cnt_A <= cnt_A + 1'b1;
      end
      if (ld_b) begin
        B     <= in;
        cnt_B <= cnt_B + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_quad_demux_router.sv
// tb_quad_demux_router: table-driven directed checks plus wrap and mid-operation reset sequences
module tb_quad_demux_router;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, S = 1'b0, E = 1'b0, A_ready = 1'b0, B_ready = 1'b0;
  logic [3:0] din = '0;
  logic in_ready, A_valid, B_valid;
  logic [3:0] A, B, cnt_A, cnt_B;
  int pass = 0, total = 0;
  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic       iv, s, e, ar, br;
    logic       rdy;
    logic [3:0] a;
    logic       av;
    logic [3:0] b;
    logic       bv;
    logic [3:0] ca, cb;
  } vec_t;
  vec_t tbl[15];
  always #5 clk = ~clk;
  quad_demux_router #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .E(E), .A(A), .A_valid(A_valid), .A_ready(A_ready),
    .B(B), .B_valid(B_valid), .B_ready(B_ready), .cnt_A(cnt_A), .cnt_B(cnt_B)
  );
  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask
  task automatic apply(input vec_t v, input string tag);
    rst = v.rst; din = v.din; in_valid = v.iv; S = v.s; E = v.e; A_ready = v.ar; B_ready = v.br;
    #1;
    chk({tag, ".in_ready"}, {3'b0, in_ready}, {3'b0, v.rdy});
    @(posedge clk);
    #1;
    chk({tag, ".A"}, A, v.a);
    chk({tag, ".A_valid"}, {3'b0, A_valid}, {3'b0, v.av});
    chk({tag, ".B"}, B, v.b);
    chk({tag, ".B_valid"}, {3'b0, B_valid}, {3'b0, v.bv});
    chk({tag, ".cnt_A"}, cnt_A, v.ca);
    chk({tag, ".cnt_B"}, cnt_B, v.cb);
    @(negedge clk);
  endtask
  initial begin
    vec_t v;
    //         rst din  iv s  e  ar br  rdy A    av B    bv cA   cB
    tbl[0]  = '{1, 4'hF, 1, 0, 1, 1, 1,  1, 4'h0, 0, 4'h0, 0, 4'd0, 4'd0};
    tbl[1]  = '{1, 4'hF, 1, 0, 1, 1, 1,  1, 4'h0, 0, 4'h0, 0, 4'd0, 4'd0};
    tbl[2]  = '{0, 4'h0, 0, 0, 1, 1, 1,  1, 4'h0, 0, 4'h0, 0, 4'd0, 4'd0};
    tbl[3]  = '{0, 4'h2, 1, 0, 1, 1, 1,  1, 4'h2, 1, 4'h0, 0, 4'd1, 4'd0};
    tbl[4]  = '{0, 4'hD, 1, 1, 1, 1, 1,  1, 4'h2, 0, 4'hD, 1, 4'd1, 4'd1};
    tbl[5]  = '{0, 4'h0, 0, 0, 1, 1, 1,  1, 4'h2, 0, 4'hD, 0, 4'd1, 4'd1};
    tbl[6]  = '{0, 4'h9, 1, 0, 1, 0, 1,  1, 4'h9, 1, 4'hD, 0, 4'd2, 4'd1};
    tbl[7]  = '{0, 4'h4, 1, 0, 1, 0, 1,  0, 4'h9, 1, 4'hD, 0, 4'd2, 4'd1};
    tbl[8]  = '{0, 4'h4, 1, 1, 1, 0, 0,  1, 4'h9, 1, 4'h4, 1, 4'd2, 4'd2};
    tbl[9]  = '{0, 4'h0, 0, 0, 1, 1, 0,  1, 4'h9, 0, 4'h4, 1, 4'd2, 4'd2};
    tbl[10] = '{0, 4'h7, 1, 1, 0, 1, 0,  0, 4'h9, 0, 4'h4, 1, 4'd2, 4'd2};
    tbl[11] = '{0, 4'h7, 1, 0, 0, 1, 0,  0, 4'h9, 0, 4'h4, 1, 4'd2, 4'd2};
    tbl[12] = '{0, 4'h7, 1, 1, 0, 1, 0,  0, 4'h9, 0, 4'h4, 1, 4'd2, 4'd2};
    tbl[13] = '{0, 4'h7, 1, 0, 0, 1, 0,  0, 4'h9, 0, 4'h4, 1, 4'd2, 4'd2};
    tbl[14] = '{0, 4'h7, 1, 1, 0, 1, 1,  0, 4'h9, 0, 4'h4, 0, 4'd2, 4'd2};
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));
    apply('{1, 4'h0, 0, 0, 1, 1, 1, 1, 4'h0, 0, 4'h0, 0, 4'd0, 4'd0}, "prewrap_rst");
    for (int i = 0; i < 17; i++) begin
      v = '{0, 4'(i), 1, 0, 1, 1, 0, 1, 4'(i), 1, 4'h0, 0, 4'((i + 1) % 16), 4'd0};
      apply(v, $sformatf("wrap%0d", i));
    end
    apply('{0, 4'h6, 1, 1, 1, 0, 0, 1, 4'h0, 1, 4'h6, 1, 4'd1, 4'd1}, "fill_b");
    apply('{0, 4'h3, 1, 0, 1, 0, 0, 0, 4'h0, 1, 4'h6, 1, 4'd1, 4'd1}, "hold_both");
    apply('{1, 4'h3, 1, 0, 1, 1, 1, 1, 4'h0, 0, 4'h0, 0, 4'd0, 4'd0}, "midop_rst");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
